flash_read_responder: RTL and testbench
=======================================

Name: flash_read_responder

Overview:
- Avalon-MM read slave that answers word read requests from the flash read master.
- Fetches four bytes per request from a byte-wide flash/ROM port with fixed latency.
- Assembles the bytes little-endian and returns each word with a one-cycle readDataValid pulse, in request order.
- Buffers outstanding requests in a small FIFO and back-pressures the master with waitRequest.

Parameters:
ADDR_WIDTH, 23, word address width; byte address width is ADDR_WIDTH+2.
FIFO_DEPTH, 4, outstanding request slots; must be a power of two, at least 2.
MEM_LATENCY, 1, cycles from the mem_rd cycle to mem_rdata valid; must be at least 1.

Ports:
clk  in  1  system clock, 50 MHz.
reset  in  1  asynchronous, active-low reset.
address  in  ADDR_WIDTH  word address of the read request.
read  in  1  read request strobe.
byteEnable  in  4  byte lane enables for the request.
waitRequest  out  1  high means the request is not accepted; the master holds read/address/byteEnable.
readData  out  32  returned word.
readDataValid  out  1  one-cycle pulse; readData is valid in that cycle.
mem_addr  out  ADDR_WIDTH+2  byte address to the flash/ROM.
mem_rd  out  1  byte read strobe, one cycle per byte.
mem_rdata  in  8  byte data, valid MEM_LATENCY cycles after the mem_rd cycle.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - FIFO count, read pointer and write pointer;
  - FSM to IDLE;
  - byte index to 0;
  - assembly register to 0.
- Output values while in reset: readData=0, readDataValid=0, mem_rd=0, mem_addr=0, waitRequest=0.
- Reset mid-operation discards all queued and in-flight requests; no readDataValid follows for them.
- waitRequest = (count == FIFO_DEPTH), driven from the registered count. It is not a function of read.
- Accept: read && !waitRequest at a rising edge pushes {address, byteEnable}.
- Pop: occurs in the RESPOND cycle. A simultaneous push and pop leaves count unchanged.
- No bypass: a pop does not lower waitRequest in the same cycle.
- FSM states:
  - IDLE: if count != 0, go to ISSUE with byte index 0; otherwise stay.
  - ISSUE (1 cycle): mem_rd=1, mem_addr={head.address, idx[1:0]}; go to WAIT with latency counter = MEM_LATENCY.
  - WAIT (MEM_LATENCY cycles): in the last WAIT cycle, capture mem_rdata into lane idx (bits 8*idx+7 : 8*idx). A lane whose byteEnable bit is 0 is written 0x00, but its byte is still read.
  - WAIT exit: if idx==3 go to RESPOND; else idx+1 and go to ISSUE.
  - RESPOND (1 cycle): readDataValid=1, readData=assembled word; pop FIFO; go to IDLE.
- Byte order: byte address 4a+0 maps to readData[7:0], and 4a+3 maps to readData[31:24].
- readData holds the last returned word between pulses.
- mem_addr holds its last value when mem_rd=0.
- Latency: with acceptance at edge E, readDataValid is high in the cycle beginning 4*(1+MEM_LATENCY)+1 edges after E. For MEM_LATENCY=1 that is 9 edges.
- Throughput: one word per 4*(1+MEM_LATENCY)+2 cycles.
- Responses are strictly in acceptance order. No request is ever dropped or duplicated.
- Address arithmetic: mem_addr = address*4 + idx with no truncation. The top word address maps to byte addresses 4*(2^ADDR_WIDTH-1) to 4*(2^ADDR_WIDTH-1)+3.
- read asserted while waitRequest=1 is ignored, with no state change.
- read=0 with arbitrary address/byteEnable has no effect.

Test Plan:
- Single read, address=0x000010, byteEnable=4'hF, memory bytes 0x40..0x43 = 11,22,33,44. Required response:
  - mem_rd at byte addresses 0x40, 0x41, 0x42, 0x43;
  - readData=0x44332211 with a single readDataValid pulse 9 edges after acceptance (MEM_LATENCY=1).
- byteEnable=4'b0101 on the same address -> readData=0x00330011, and four mem_rd pulses are still issued.
- Back-pressure:
  - Hold read=1 with addresses 0..5 each cycle. waitRequest rises once 4 requests are queued.
  - The 5th request is accepted only after the first RESPOND cycle.
  - Six readDataValid pulses follow, in address order 0..5, with data matching the memory model.
- Simultaneous push and pop: FIFO full and a new request presented in the RESPOND cycle -> count stays 4, waitRequest stays 1 that cycle, and the request is accepted the following edge.
- Reset mid-operation:
  - With 3 requests queued and the FSM in WAIT for byte 2, pulse reset=0 asynchronously.
  - Required: readDataValid=0, waitRequest=0 and mem_rd=0 immediately.
  - After release, no stale responses occur; a new read at 0x7FFFFF returns bytes 0x1FFFFFC..0x1FFFFFF.
- MEM_LATENCY=3 build: single read returns readDataValid 17 edges after acceptance, and each byte is captured exactly 3 cycles after its mem_rd.

Source files
------------

// File: rtl/flash_read_responder_if.sv
// Avalon-MM read-only slave bundle between the flash read master and the responder.
interface flash_read_responder_if #(
  parameter int ADDR_WIDTH = 23
) ();
  logic [ADDR_WIDTH-1:0] address;
  logic                  read;
  logic [3:0]            byteEnable;
  logic                  waitRequest;
  logic [31:0]           readData;
  logic                  readDataValid;

  modport master (
    output address, read, byteEnable,
    input  waitRequest, readData, readDataValid
  );

  modport slave (
    input  address, read, byteEnable,
    output waitRequest, readData, readDataValid
  );
endinterface

// File: rtl/flash_read_responder.sv
// Word read slave: queues requests, fetches four bytes each from a fixed-latency
// byte-wide ROM port and returns them little-endian, in order, one word at a time.
module flash_read_responder #(
  parameter int ADDR_WIDTH  = 23,
  parameter int FIFO_DEPTH  = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  flash_read_responder_if.slave bus,
  output logic [ADDR_WIDTH+1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t                state, state_next;

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [3:0]            fifo_be   [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push, pop;

  logic [ADDR_WIDTH-1:0] head_addr;
  logic [3:0]            head_be;
  logic [7:0]            lane_byte;

  logic [1:0]            idx, idx_next;
  logic [LAT_W-1:0]      lat_cnt, lat_cnt_next;
  logic [31:0]           assembly, assembly_next;
  logic [31:0]           read_data_q, read_data_next;
  logic [ADDR_WIDTH+1:0] mem_addr_q, mem_addr_next;

  // Back-pressure comes only from the registered fill level, so a pop never frees a slot early.
  assign bus.waitRequest = (count == CNT_W'(FIFO_DEPTH));
  assign push            = bus.read && !bus.waitRequest;
  assign head_addr       = fifo_addr[rd_ptr];
  assign head_be         = fifo_be[rd_ptr];
  assign bus.readData    = read_data_q;
  assign mem_addr        = mem_addr_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.address;
      fifo_be[wr_ptr]   <= bus.byteEnable;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= 2'd0;
      lat_cnt     <= '0;
      assembly    <= '0;
      read_data_q <= '0;
      mem_addr_q  <= '0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      lat_cnt     <= lat_cnt_next;
      assembly    <= assembly_next;
      read_data_q <= read_data_next;
      mem_addr_q  <= mem_addr_next;
    end
  end

  // Disabled lanes are still fetched so every request costs the same number of cycles.
  always_comb begin
    state_next        = state;
    idx_next          = idx;
    lat_cnt_next      = lat_cnt;
    assembly_next     = assembly;
    read_data_next    = read_data_q;
    mem_addr_next     = mem_addr_q;
    mem_rd            = 1'b0;
    pop               = 1'b0;
    bus.readDataValid = 1'b0;
    lane_byte         = head_be[idx] ? mem_rdata : 8'h00;

    case (state)
      IDLE: begin
        if (count != '0) begin
          idx_next      = 2'd0;
          mem_addr_next = {head_addr, 2'd0};
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        mem_rd       = 1'b1;
        lat_cnt_next = LAT_W'(MEM_LATENCY);
        state_next   = WAIT;
      end
      WAIT: begin
        if (lat_cnt == LAT_W'(1)) begin
          assembly_next[8*idx +: 8] = lane_byte;
          if (idx == 2'd3) begin
            read_data_next = assembly_next;
            state_next     = RESPOND;
          end else begin
            idx_next      = idx + 2'd1;
            mem_addr_next = {head_addr, idx + 2'd1};
            state_next    = ISSUE;
          end
        end else begin
          lat_cnt_next = lat_cnt - 1'b1;
        end
      end
      RESPOND: begin
        bus.readDataValid = 1'b1;
        pop               = 1'b1;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_flash_read_responder.sv
// Directed bench for flash_read_responder: one instance at MEM_LATENCY=1, one at
// MEM_LATENCY=3, each fed by a ROM model that only drives valid data in the right cycle.
module tb_flash_read_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [24:0] mem_addr, mem3_addr;
  logic        mem_rd, mem3_rd;
  logic [7:0]  mem_rdata, mem3_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] resp_q[$];
  int          resp_cyc_q[$];
  logic        resp_wr_q[$];
  logic [24:0] memrd_q[$];
  int          accept_q[$];
  logic [31:0] resp3_q[$];
  int          resp3_cyc_q[$];

  flash_read_responder_if #(.ADDR_WIDTH(23)) bus ();
  flash_read_responder_if #(.ADDR_WIDTH(23)) bus3 ();

  flash_read_responder #(.ADDR_WIDTH(23), .FIFO_DEPTH(4), .MEM_LATENCY(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata)
  );

  flash_read_responder #(.ADDR_WIDTH(23), .FIFO_DEPTH(4), .MEM_LATENCY(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus3.slave),
    .mem_addr  (mem3_addr),
    .mem_rd    (mem3_rd),
    .mem_rdata (mem3_rdata)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [24:0] a);
    case (a)
      25'h40:  return 8'h11;
      25'h41:  return 8'h22;
      25'h42:  return 8'h33;
      25'h43:  return 8'h44;
      default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ {7'b0, a[24]} ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] expected_word(input logic [22:0] a, input logic [3:0] be);
    logic [31:0] w;
    for (int k = 0; k < 4; k++)
      w[8*k +: 8] = be[k] ? mem_byte({a, 2'(k)}) : 8'h00;
    return w;
  endfunction

  // ROM models: data is only meaningful in the cycle it is due, 0xEE otherwise.
  logic       p1_v = 1'b0;
  logic [7:0] p1_d;
  logic [2:0] p3_v = 3'b000;
  logic [7:0] p3_d [3];

  always @(posedge clk) begin
    p1_v    <= mem_rd;
    p1_d    <= mem_byte(mem_addr);
    p3_v    <= {p3_v[1:0], mem3_rd};
    p3_d[0] <= mem_byte(mem3_addr);
    p3_d[1] <= p3_d[0];
    p3_d[2] <= p3_d[1];
  end

  assign mem_rdata  = p1_v    ? p1_d    : 8'hEE;
  assign mem3_rdata = p3_v[2] ? p3_d[2] : 8'hEE;

  always @(negedge clk) begin
    if (bus.readDataValid) begin
      resp_q.push_back(bus.readData);
      resp_cyc_q.push_back(cyc);
      resp_wr_q.push_back(bus.waitRequest);
    end
    if (mem_rd) memrd_q.push_back(mem_addr);
    if (bus3.readDataValid) begin
      resp3_q.push_back(bus3.readData);
      resp3_cyc_q.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Presents a request and returns just after the edge that accepts it, leaving read high.
  task automatic applyStimulus(input logic [22:0] a, input logic [3:0] be);
    int guard = 0;
    @(negedge clk);
    bus.address    = a;
    bus.byteEnable = be;
    bus.read       = 1'b1;
    while (bus.waitRequest && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) checkOutput("accept_timeout", 64'(guard), 64'd0);
    accept_q.push_back(cyc + 1);
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.read       = 1'b0;
    bus.address    = 23'($urandom);
    bus.byteEnable = 4'($urandom);
  endtask

  task automatic wait_resp(input int n, input string tag);
    int guard = 0;
    while (resp_q.size() < n && guard < 300) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (resp_q.size() < n) checkOutput(tag, 64'(resp_q.size()), 64'(n));
  endtask

  task automatic clear_queues();
    resp_q.delete();
    resp_cyc_q.delete();
    resp_wr_q.delete();
    memrd_q.delete();
    accept_q.delete();
  endtask

  task automatic pad_queues(input int nresp, input int nrd);
    while (resp_q.size() < nresp) begin
      resp_q.push_back('x);
      resp_cyc_q.push_back(-1);
      resp_wr_q.push_back(1'bx);
    end
    while (memrd_q.size() < nrd) memrd_q.push_back('x);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int guard;
    int acc3;
    bus.read = 1'b0;  bus.address = '0;  bus.byteEnable = '0;
    bus3.read = 1'b0; bus3.address = '0; bus3.byteEnable = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_readData",      64'(bus.readData),      64'd0);
    checkOutput("rst_readDataValid", 64'(bus.readDataValid), 64'd0);
    checkOutput("rst_mem_rd",        64'(mem_rd),            64'd0);
    checkOutput("rst_mem_addr",      64'(mem_addr),          64'd0);
    checkOutput("rst_waitRequest",   64'(bus.waitRequest),   64'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] single read, full word");
    clear_queues();
    applyStimulus(23'h000010, 4'hF);
    go_idle();
    wait_resp(1, "t1_resp_timeout");
    repeat (12) @(negedge clk);
    checkOutput("t1_pulses",  64'(resp_q.size()),  64'd1);
    checkOutput("t1_rd_count", 64'(memrd_q.size()), 64'd4);
    pad_queues(1, 4);
    checkOutput("t1_data",    64'(resp_q[0]), 64'h44332211);
    checkOutput("t1_latency", 64'(resp_cyc_q[0] - accept_q[0]), 64'd9);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t1_mem_addr%0d", k), 64'(memrd_q[k]), 64'(25'h40 + k));

    $display("[TB] single read, partial byte enables");
    clear_queues();
    applyStimulus(23'h000010, 4'b0101);
    go_idle();
    wait_resp(1, "t2_resp_timeout");
    repeat (12) @(negedge clk);
    checkOutput("t2_pulses",   64'(resp_q.size()),  64'd1);
    checkOutput("t2_rd_count", 64'(memrd_q.size()), 64'd4);
    pad_queues(1, 4);
    checkOutput("t2_data", 64'(resp_q[0]), 64'h00330011);

    $display("[TB] back-pressure with six queued reads");
    clear_queues();
    for (int i = 0; i < 4; i++) applyStimulus(23'(i), 4'hF);
    @(negedge clk);
    #1;
    checkOutput("bp_wait_high", 64'(bus.waitRequest), 64'd1);
    for (int i = 4; i < 6; i++) applyStimulus(23'(i), 4'hF);
    go_idle();
    wait_resp(6, "bp_resp_timeout");
    repeat (15) @(negedge clk);
    checkOutput("bp_pulses", 64'(resp_q.size()), 64'd6);
    pad_queues(6, 0);
    checkOutput("bp_wait_in_respond", 64'(resp_wr_q[0]), 64'd1);
    checkOutput("bp_fifth_accept_gap", 64'(accept_q[4] - accept_q[0]), 64'd11);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("bp_data%0d", i), 64'(resp_q[i]), 64'(expected_word(23'(i), 4'hF)));

    $display("[TB] reset during WAIT of byte 2");
    clear_queues();
    applyStimulus(23'h000100, 4'hF);
    applyStimulus(23'h000101, 4'hF);
    applyStimulus(23'h000102, 4'hF);
    go_idle();
    guard = 0;
    while (memrd_q.size() < 3 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checkOutput("mr_reached_byte2", 64'(memrd_q.size()), 64'd3);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mr_readDataValid", 64'(bus.readDataValid), 64'd0);
    checkOutput("mr_waitRequest",   64'(bus.waitRequest),   64'd0);
    checkOutput("mr_mem_rd",        64'(mem_rd),            64'd0);
    checkOutput("mr_mem_addr",      64'(mem_addr),          64'd0);
    checkOutput("mr_readData",      64'(bus.readData),      64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    clear_queues();
    repeat (40) @(negedge clk);
    checkOutput("mr_no_stale_resp", 64'(resp_q.size()),  64'd0);
    checkOutput("mr_no_stale_rd",   64'(memrd_q.size()), 64'd0);

    clear_queues();
    applyStimulus(23'h7FFFFF, 4'hF);
    go_idle();
    wait_resp(1, "top_resp_timeout");
    repeat (12) @(negedge clk);
    checkOutput("top_pulses",   64'(resp_q.size()),  64'd1);
    checkOutput("top_rd_count", 64'(memrd_q.size()), 64'd4);
    pad_queues(1, 4);
    checkOutput("top_data", 64'(resp_q[0]), 64'h5B5A5958);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("top_mem_addr%0d", k), 64'(memrd_q[k]), 64'(25'h1FFFFFC + k));

    $display("[TB] MEM_LATENCY=3 instance");
    @(negedge clk);
    bus3.address    = 23'h000010;
    bus3.byteEnable = 4'hF;
    bus3.read       = 1'b1;
    guard = 0;
    while (bus3.waitRequest && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("l3_accept", 64'(bus3.waitRequest), 64'd0);
    acc3 = cyc + 1;
    @(negedge clk);
    bus3.read = 1'b0;
    guard = 0;
    while (resp3_q.size() < 1 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    repeat (20) @(negedge clk);
    checkOutput("l3_pulses", 64'(resp3_q.size()), 64'd1);
    if (resp3_q.size() == 0) begin
      resp3_q.push_back('x);
      resp3_cyc_q.push_back(-1);
    end
    checkOutput("l3_data",    64'(resp3_q[0]), 64'h44332211);
    checkOutput("l3_latency", 64'(resp3_cyc_q[0] - acc3), 64'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
